demux16x16_buffered: RTL and testbench

Write-side counterpart of the 16-way 16-bit selector. It accepts one data word per handshake and steers it into one of 16 per-channel holding registers chosen by a 4-bit select or an internal auto-incrementing pointer. Each channel holds its word with a valid flag until the downstream consumer acknowledges it. The block sits between a single producer (datapath or bus) and 16 independent consumers such as register-file write ports or peripheral inputs.

---
 rtl/demux16x16_buffered.sv | 106 ++++++++++
 tb/tb_demux16x16_buffered.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/demux16x16_buffered.sv
// rtl/demux16x16_buffered.sv - 16-way buffered write demux with per-channel valid/ack (optional DEMUX_BROADCAST_EN)
module demux16x16_buffered #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       sel,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             burst,
    input  logic             bcast,
    input  logic [15:0]      ack,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [WIDTH-1:0] out9,
    output logic [WIDTH-1:0] out10,
    output logic [WIDTH-1:0] out11,
    output logic [WIDTH-1:0] out12,
    output logic [WIDTH-1:0] out13,
    output logic [WIDTH-1:0] out14,
    output logic [WIDTH-1:0] out15,
    output logic [15:0]      out_valid,
    output logic [3:0]       ptr
);

    logic [WIDTH-1:0] hold [16];
    logic [3:0]       tgt;
    logic [15:0]      free;
    logic [15:0]      wr_mask;
    logic             bc_active;
    logic             xfer;

`ifdef DEMUX_BROADCAST_EN
    assign bc_active = bcast;
`else
    logic unused_bcast;
    assign unused_bcast = bcast;
    assign bc_active    = 1'b0;
`endif

    assign tgt  = burst ? ptr : sel;
    // A slot being acknowledged this cycle can be overwritten in the same cycle.
    assign free = ~out_valid | ack;

    assign in_ready = enable & (bc_active ? (&free) : free[tgt]);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        wr_mask = 16'h0000;
        if (xfer) begin
            if (bc_active)
                wr_mask = 16'hFFFF;
            else
                wr_mask = 16'h0001 << tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                hold[i] <= '0;
            out_valid <= 16'h0000;
            ptr       <= 4'd0;
        end else begin
            // Write wins over a same-cycle ack on the same slot.
            for (int i = 0; i < 16; i++) begin
                if (wr_mask[i]) begin
                    hold[i]      <= data;
                    out_valid[i] <= 1'b1;
                end else if (ack[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            // Both burst and direct writes leave ptr just past the written slot.
            if (xfer && !bc_active)
                ptr <= tgt + 4'd1;
        end
    end

    assign out0  = hold[0];
    assign out1  = hold[1];
    assign out2  = hold[2];
    assign out3  = hold[3];
    assign out4  = hold[4];
    assign out5  = hold[5];
    assign out6  = hold[6];
    assign out7  = hold[7];
    assign out8  = hold[8];
    assign out9  = hold[9];
    assign out10 = hold[10];
    assign out11 = hold[11];
    assign out12 = hold[12];
    assign out13 = hold[13];
    assign out14 = hold[14];
    assign out15 = hold[15];

endmodule

// File: tb/tb_demux16x16_buffered.sv
// tb/tb_demux16x16_buffered.sv - randomized model-checked bench for demux16x16_buffered
module tb_demux16x16_buffered;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  sel;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic        burst;
    logic        bcast;
    logic [15:0] ack;
    logic [15:0] o [16];
    logic [15:0] out_valid;
    logic [3:0]  ptr;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_data [16];
    logic [15:0] m_valid;
    int          m_ptr;

    always #5 clk = ~clk;

    demux16x16_buffered #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .data(data), .sel(sel), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .burst(burst), .bcast(bcast), .ack(ack),
        .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]),
        .out4(o[4]), .out5(o[5]), .out6(o[6]), .out7(o[7]),
        .out8(o[8]), .out9(o[9]), .out10(o[10]), .out11(o[11]),
        .out12(o[12]), .out13(o[13]), .out14(o[14]), .out15(o[15]),
        .out_valid(out_valid), .ptr(ptr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_bcast();
`ifdef DEMUX_BROADCAST_EN
        return bcast;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        int t;
        bit all_free;
        t = burst ? m_ptr : int'(sel);
        all_free = 1'b1;
        for (int i = 0; i < 16; i++)
            if (m_valid[i] && !ack[i]) all_free = 1'b0;
        if (!enable) return 1'b0;
        if (model_bcast()) return all_free;
        return !m_valid[t] || ack[t];
    endfunction

    function automatic void model_step();
        int t;
        bit go;
        t  = burst ? m_ptr : int'(sel);
        go = in_valid && model_ready();
        if (reset) begin
            for (int i = 0; i < 16; i++) m_data[i] = 16'h0;
            m_valid = 16'h0;
            m_ptr   = 0;
            return;
        end
        m_valid = m_valid & ~ack;
        if (go) begin
            if (model_bcast()) begin
                for (int i = 0; i < 16; i++) m_data[i] = data;
                m_valid = 16'hFFFF;
            end else begin
                m_data[t]  = data;
                m_valid[t] = 1'b1;
                m_ptr      = (t + 1) % 16;
            end
        end
    endfunction

    task automatic compare_state();
        chk("out_valid", {16'h0, out_valid}, {16'h0, m_valid});
        chk("ptr", {28'h0, ptr}, m_ptr);
        for (int i = 0; i < 16; i++)
            chk($sformatf("out%0d", i), {16'h0, o[i]}, {16'h0, m_data[i]});
    endtask

    // Inputs must already be set; checks in_ready, advances one edge, checks state.
    task automatic cycle();
        #1;
        if (!reset) chk("in_ready", {31'h0, in_ready}, {31'h0, model_ready()});
        model_step();
        @(posedge clk);
        #1;
        compare_state();
    endtask

    task automatic idle_inputs();
        in_valid = 0; ack = 16'h0; burst = 0; bcast = 0; enable = 1; sel = 0; data = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        for (int i = 0; i < 16; i++) m_data[i] = 16'hxxxx;
        m_valid = 16'hxxxx;
        m_ptr   = 0;
        cycle();
        cycle();
        reset = 0;
        #1;
        chk("reset out_valid", {16'h0, out_valid}, 32'h0);
        chk("reset ptr", {28'h0, ptr}, 32'h0);
        chk("reset in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset out9", {16'h0, o[9]}, 32'h0);

        // direct write
        sel = 5; data = 16'hA5A5; in_valid = 1;
        cycle();
        chk("dw out5", {16'h0, o[5]}, 32'hA5A5);
        chk("dw out_valid", {16'h0, out_valid}, 32'h0020);
        chk("dw ptr", {28'h0, ptr}, 32'h6);
        data = 16'h5A5A;
        #1 chk("dw full ready", {31'h0, in_ready}, 32'h0);
        ack = 16'h0020;
        #1 chk("dw ack ready", {31'h0, in_ready}, 32'h1);
        cycle();
        chk("dw ack valid5", {31'h0, out_valid[5]}, 32'h1);
        chk("dw ack out5", {16'h0, o[5]}, 32'h5A5A);
        ack = 0;

        // burst wrap
        sel = 14; data = 16'hBEEF;
        cycle();
        burst = 1;
        for (int k = 1; k <= 3; k++) begin
            data = 16'(k);
            cycle();
        end
        chk("bw out14", {16'h0, o[14]}, 32'hBEEF);
        chk("bw out15", {16'h0, o[15]}, 32'h1);
        chk("bw out0", {16'h0, o[0]}, 32'h2);
        chk("bw out1", {16'h0, o[1]}, 32'h3);
        chk("bw ptr", {28'h0, ptr}, 32'h2);
        chk("bw out_valid", {16'h0, out_valid}, 32'hC023);

        // enable low
        burst = 0; enable = 0; sel = 3; data = 16'h7777; ack = 16'h4000;
        for (int k = 0; k < 4; k++) begin
            #1 chk("en0 ready", {31'h0, in_ready}, 32'h0);
            cycle();
            ack = 0;
        end
        chk("en0 out3", {16'h0, o[3]}, 32'h0);
        chk("en0 out_valid", {16'h0, out_valid}, 32'h8023);
        enable = 1;

        // reset mid-operation with 00FF valid
        ack = 16'hFFFF; in_valid = 0;
        cycle();
        ack = 0; in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            sel = 4'(k); data = 16'h1000 + 16'(k);
            cycle();
        end
        chk("pre-reset valid", {16'h0, out_valid}, 32'h00FF);
        sel = 8; data = 16'hDEAD; reset = 1;
        cycle();
        reset = 0; in_valid = 0;
        chk("mid reset valid", {16'h0, out_valid}, 32'h0);
        chk("mid reset ptr", {28'h0, ptr}, 32'h0);
        chk("mid reset out8", {16'h0, o[8]}, 32'h0);

`ifdef DEMUX_BROADCAST_EN
        bcast = 1; in_valid = 1; data = 16'h1234; sel = 9;
        cycle();
        chk("bc out_valid", {16'h0, out_valid}, 32'hFFFF);
        chk("bc out11", {16'h0, o[11]}, 32'h1234);
        chk("bc ptr", {28'h0, ptr}, 32'h0);
        ack = 16'hFF7F;
        #1 chk("bc blocked", {31'h0, in_ready}, 32'h0);
        cycle();
        ack = 0; bcast = 0; in_valid = 0;
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            burst    = $urandom_range(0, 1);
            bcast    = ($urandom_range(0, 19) == 0);
            sel      = 4'($urandom_range(0, 15));
            data     = 16'($urandom);
            ack      = 16'($urandom) & 16'($urandom);
            cycle();
        end
        reset = 0;
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
